// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with accumulator.
// Stage 1 resolves the low half and its carry-out; stage 2 finishes the high half.
module cla_adder_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [WIDTH-1:0] acc
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned NGRP = HALF / GROUP;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  // Half-width two-level CLA: returns {carry_out, sum}.
  function automatic logic [HALF:0] cla_half(input logic [HALF-1:0] x,
                                             input logic [HALF-1:0] y,
                                             input logic            c0);
    logic [HALF-1:0] g, p, c;
    logic [NGRP-1:0] gg, gp;
    logic [NGRP:0]   gc;
    logic            t, cc;
    g = x & y;
    p = x | y;
    c = '0;
    for (int k = 0; k < int'(NGRP); k++) begin
      gg[k] = 1'b0;
      gp[k] = 1'b1;
      for (int i = 0; i < int'(GROUP); i++) begin
        gg[k] = g[k*GROUP+i] | (p[k*GROUP+i] & gg[k]);
        gp[k] = gp[k] & p[k*GROUP+i];
      end
    end
    // Second level: every group carry straight from c0 and group G/P terms
    gc[0] = c0;
    for (int k = 0; k < int'(NGRP); k++) begin
      gc[k+1] = gg[k];
      t = gp[k];
      for (int j = k - 1; j >= 0; j--) begin
        gc[k+1] = gc[k+1] | (t & gg[j]);
        t = t & gp[j];
      end
      gc[k+1] = gc[k+1] | (t & c0);
    end
    // Bit carries inside each group, looked ahead from the group carry-in
    for (int k = 0; k < int'(NGRP); k++) begin
      for (int i = 0; i < int'(GROUP); i++) begin
        cc = 1'b0;
        t  = 1'b1;
        for (int j = i - 1; j >= 0; j--) begin
          cc = cc | (t & g[k*GROUP+j]);
          t  = t & p[k*GROUP+j];
        end
        c[k*GROUP+i] = cc | (t & gc[k]);
      end
    end
    return {gc[NGRP], x ^ y ^ c};
  endfunction

  logic             s1_valid;
  logic             s1_acc_op;
  logic [HALF-1:0]  s1_lo;
  logic             s1_cmid;
  logic [HALF-1:0]  s1_a_hi;
  logic [HALF-1:0]  s1_b_hi;

  logic [WIDTH-1:0] opa, opb;
  logic             c0;
  logic [HALF:0]    lo_res, hi_res;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout, res_ovf;
  logic             adv1, adv2, accept;

  // Operand mapping onto a single adder
  always_comb begin
    opa = a;
    opb = b;
    c0  = cin;
    case (op)
      OP_ADD:  ;
      OP_SUB:  begin opb = ~b; c0 = 1'b1; end
      OP_ACC:  opb = acc;
      OP_LOAD: begin opa = '0; opb = a; c0 = 1'b0; end
      default: ;
    endcase
  end

  assign lo_res   = cla_half(opa[HALF-1:0], opb[HALF-1:0], c0);
  assign hi_res   = cla_half(s1_a_hi, s1_b_hi, s1_cmid);
  assign res_sum  = {hi_res[HALF-1:0], s1_lo};
  assign res_cout = hi_res[HALF];
  // Carry into the MSB recovered from the MSB sum bit and its operands
  assign res_ovf  = res_cout ^ (s1_a_hi[HALF-1] ^ s1_b_hi[HALF-1] ^ hi_res[HALF-1]);

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  // ACC/LOAD in stage 1 blocks intake until acc has been written back
  assign in_ready = adv1 && !(s1_valid && s1_acc_op);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_acc_op <= 1'b0;
      s1_lo     <= '0;
      s1_cmid   <= 1'b0;
      s1_a_hi   <= '0;
      s1_b_hi   <= '0;
    end else if (adv1) begin
      s1_valid <= accept;
      if (accept) begin
        s1_acc_op <= op[1];
        s1_lo     <= lo_res[HALF-1:0];
        s1_cmid   <= lo_res[HALF];
        s1_a_hi   <= opa[WIDTH-1:HALF];
        s1_b_hi   <= opb[WIDTH-1:HALF];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      acc       <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= res_sum;
        cout <= res_cout;
        ovf  <= res_ovf;
        zero <= (res_sum == '0);
        if (s1_acc_op) acc <= res_sum;
      end
    end
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe: directed corner cases, then random
// traffic against an arithmetic reference model with a result queue.
module tb_cla_adder_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic [15:0] acc;

  cla_adder_pipe #(.WIDTH(16), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf),
    .zero(zero), .acc(acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [19:0] q[$];          // {is_acc_op, zero, ovf, cout, sum}
  logic [15:0] acc_m;
  logic        held;
  logic [18:0] held_val;
  logic [18:0] last_out;      // {zero, ovf, cout, sum} of last popped result
  logic        rdy_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's meaning
  function automatic logic [19:0] model(input logic [1:0] o, input logic [15:0] x,
                                        input logic [15:0] y, input logic c,
                                        input logic [15:0] accv);
    int unsigned u;
    int          s;
    logic        co;
    logic        ov;
    logic [15:0] r;
    u  = 0;
    s  = 0;
    co = 1'b0;
    case (o)
      2'b00: begin
        u  = 32'(x) + 32'(y) + 32'(c);
        s  = int'($signed(x)) + int'($signed(y)) + int'(c);
        co = (u > 32'd65535);
      end
      2'b01: begin
        u  = 32'(x) - 32'(y);
        s  = int'($signed(x)) - int'($signed(y));
        co = (x >= y);
      end
      2'b10: begin
        u  = 32'(x) + 32'(accv) + 32'(c);
        s  = int'($signed(x)) + int'($signed(accv)) + int'(c);
        co = (u > 32'd65535);
      end
      default: begin
        u  = 32'(x);
        s  = int'($signed(x));
        co = 1'b0;
      end
    endcase
    r  = u[15:0];
    ov = (s > 32767) || (s < -32768);
    return {o[1], (r == 16'h0000), ov, co, r};
  endfunction

  // One clock cycle: drive at negedge, check pops / holds, update model, clock.
  task automatic cycle(input logic v, input logic [1:0] o, input logic [15:0] x,
                       input logic [15:0] y, input logic c, input logic ordy,
                       output logic took);
    logic [19:0] e;
    rst       = 1'b0;
    in_valid  = v;
    op        = o;
    a         = x;
    b         = y;
    cin       = c;
    out_ready = ordy;
    #1;
    if (held) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'({zero, ovf, cout, sum}), 32'(held_val));
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        check("sum", 32'(sum), 32'(e[15:0]));
        check("cout", 32'(cout), 32'(e[16]));
        check("ovf", 32'(ovf), 32'(e[17]));
        check("zero", 32'(zero), 32'(e[18]));
        if (e[19]) check("acc_wb", 32'(acc), 32'(e[15:0]));
      end
      last_out = {zero, ovf, cout, sum};
    end
    held     = out_valid && !out_ready;
    held_val = {zero, ovf, cout, sum};
    rdy_s    = in_ready;
    took     = in_valid && in_ready;
    if (took) begin
      e = model(o, x, y, c, acc_m);
      q.push_back(e);
      if (o[1]) acc_m = e[15:0];
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                      input logic c);
    logic took;
    took = 1'b0;
    for (int n = 0; n < 20 && !took; n++) cycle(1'b1, o, x, y, c, 1'b1, took);
    if (!took) check("send_timeout", 32'(took), 32'd1);
  endtask

  task automatic drain(output int n);
    logic took;
    n = 0;
    while (q.size() > 0 && n < 40) begin
      cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b1, took);
      n++;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic took;
    int   n;
    rst = 1'b1; in_valid = 1'b0; op = 2'b00; a = '0; b = '0; cin = 1'b0;
    out_ready = 1'b0; acc_m = '0; held = 1'b0; held_val = '0; last_out = '0; rdy_s = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_flags", 32'({cout, ovf, zero}), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // ADD wrap to zero; result visible two cycles after the beat is presented
    cycle(1'b1, 2'b00, 16'hFFFF, 16'h0001, 1'b0, 1'b1, took);
    check("add1_accept", 32'(took), 32'd1);
    check("lat_stage1", 32'(out_valid), 32'd0);
    cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b1, took);
    check("lat_stage2", 32'(out_valid), 32'd1);
    check("add1_result", 32'({zero, ovf, cout, sum}), 32'({1'b1, 1'b0, 1'b1, 16'h0000}));
    drain(n);

    send(2'b00, 16'h00FF, 16'h0000, 1'b1);
    drain(n);
    check("add_carry_chain", 32'({last_out[16], last_out[15:0]}), 32'({1'b0, 16'h0100}));
    send(2'b00, 16'h7FFF, 16'h0001, 1'b0);
    drain(n);
    check("add_ovf", 32'({last_out[17], last_out[15:0]}), 32'({1'b1, 16'h8000}));

    send(2'b01, 16'h8000, 16'h0001, 1'b0);
    drain(n);
    check("sub_ovf", 32'(last_out), 32'({1'b0, 1'b1, 1'b1, 16'h7FFF}));
    send(2'b01, 16'h0003, 16'h0005, 1'b1);
    drain(n);
    check("sub_borrow", 32'(last_out), 32'({1'b0, 1'b0, 1'b0, 16'hFFFE}));

    // Four ADDs into a stalled output, then release
    cycle(1'b1, 2'b00, 16'h1111, 16'h0001, 1'b0, 1'b0, took);
    check("b2b_acc1", 32'(took), 32'd1);
    cycle(1'b1, 2'b00, 16'h2222, 16'h0002, 1'b0, 1'b0, took);
    check("b2b_acc2", 32'(took), 32'd1);
    cycle(1'b1, 2'b00, 16'h3333, 16'h0003, 1'b0, 1'b0, took);
    check("b2b_full_ready", 32'(rdy_s), 32'd0);
    cycle(1'b1, 2'b00, 16'h3333, 16'h0003, 1'b0, 1'b0, took);
    check("b2b_full_ready2", 32'(rdy_s), 32'd0);
    cycle(1'b1, 2'b00, 16'h3333, 16'h0003, 1'b0, 1'b1, took);
    check("b2b_push_pop", 32'(took), 32'd1);
    cycle(1'b1, 2'b00, 16'h4444, 16'h0004, 1'b0, 1'b1, took);
    check("b2b_acc4", 32'(took), 32'd1);
    drain(n);
    check("b2b_no_bubble", 32'(n), 32'd2);

    // LOAD / ACC chain: one beat every other cycle
    cycle(1'b1, 2'b11, 16'h0005, 16'hAAAA, 1'b1, 1'b1, took);
    check("load_accept", 32'(took), 32'd1);
    cycle(1'b1, 2'b10, 16'h0007, 16'h0, 1'b0, 1'b1, took);
    check("acc1_blocked", 32'(took), 32'd0);
    cycle(1'b1, 2'b10, 16'h0007, 16'h0, 1'b0, 1'b1, took);
    check("acc1_accept", 32'(took), 32'd1);
    cycle(1'b1, 2'b10, 16'hFFFF, 16'h0, 1'b0, 1'b1, took);
    check("acc2_blocked", 32'(took), 32'd0);
    cycle(1'b1, 2'b10, 16'hFFFF, 16'h0, 1'b0, 1'b1, took);
    check("acc2_accept", 32'(took), 32'd1);
    drain(n);
    check("acc_chain_result", 32'({last_out[16], last_out[15:0]}), 32'({1'b1, 16'h000B}));
    check("acc_value", 32'(acc), 32'h000B);

    // Reset with two beats in flight
    cycle(1'b1, 2'b00, 16'h0001, 16'h0002, 1'b0, 1'b0, took);
    cycle(1'b1, 2'b00, 16'h0003, 16'h0004, 1'b0, 1'b0, took);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_acc", 32'(acc), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    acc_m = '0;
    held  = 1'b0;
    for (int i = 0; i < 5; i++) cycle(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b1, took);
    check("flush_never_emitted", 32'(out_valid), 32'd0);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom), 16'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom_range(0, 3) != 0), took);
    end
    drain(n);
    check("rand_acc_final", 32'(acc), 32'(acc_m));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
